// File: rtl/stopwatch_lap.sv
// Minutes:seconds stopwatch with run/pause FSM, prescaled tick, sticky wrap flag
// and a small FIFO of captured lap times.
module stopwatch_lap #(
   parameter int TICK_DIV  = 1,
   parameter int MIN_W     = 7,
   parameter int MAX_MIN   = 99,
   parameter int LAP_DEPTH = 4
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             start,
   input  logic                             stop,
   input  logic                             clear,
   input  logic                             lap,
   input  logic                             lap_rd,
   output logic [5:0]                       seconds,
   output logic [MIN_W-1:0]                 minutes,
   output logic [1:0]                       state,
   output logic                             overflow,
   output logic                             lap_valid,
   output logic [5:0]                       lap_sec,
   output logic [MIN_W-1:0]                 lap_min,
   output logic [$clog2(LAP_DEPTH+1)-1:0]   lap_count,
   output logic                             lap_ovf
);

   localparam int CNT_W = $clog2(LAP_DEPTH + 1);
   localparam int PTR_W = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1;
   localparam int PS_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(TICK_DIV - 1);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(LAP_DEPTH - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(LAP_DEPTH);
   localparam logic [MIN_W-1:0] MIN_LAST = MIN_W'(MAX_MIN);

   typedef enum logic [1:0] {IDLE = 2'b00, RUNNING = 2'b01, PAUSED = 2'b10} state_e;

   state_e            state_q, state_d;
   logic              running, active;
   logic [PS_W-1:0]   presc_q, presc_d;
   logic [5:0]        sec_q, sec_d;
   logic [MIN_W-1:0]  min_q, min_d;
   logic              ovf_q, ovf_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              lap_ovf_q, lap_ovf_d;
   logic              tick, push, pop, full, wr_en;
   logic [5:0]        sec_mem [LAP_DEPTH];
   logic [MIN_W-1:0]  min_mem [LAP_DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // clear beats stop beats start; start with stop never leaves IDLE/PAUSED
   always_comb begin
      state_d = state_q;
      if (clear) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    if (start && !stop) state_d = RUNNING;
            RUNNING: if (stop)           state_d = PAUSED;
            PAUSED:  if (start && !stop) state_d = RUNNING;
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      state   = state_q;
      running = (state_q == RUNNING);
      active  = (state_q != IDLE);
   end

   always_comb begin
      tick      = running && (presc_q == PS_LAST);
      full      = (cnt_q == CNT_FULL);
      pop       = lap_rd && (cnt_q != '0) && !clear;
      push      = lap && active && !clear;
      wr_en     = push && (!full || pop);
      presc_d   = presc_q;
      sec_d     = sec_q;
      min_d     = min_q;
      ovf_d     = ovf_q;
      rd_ptr_d  = rd_ptr_q;
      wr_ptr_d  = wr_ptr_q;
      cnt_d     = cnt_q;
      lap_ovf_d = lap_ovf_q;
      if (!active)      presc_d = '0;
      else if (running) presc_d = tick ? '0 : presc_q + 1'b1;
      if (tick) begin
         if (sec_q == 6'd59) begin
            sec_d = '0;
            if (min_q == MIN_LAST) begin
               min_d = '0;
               ovf_d = 1'b1;
            end else begin
               min_d = min_q + 1'b1;
            end
         end else begin
            sec_d = sec_q + 1'b1;
         end
      end
      if (pop)   rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
      if (wr_en) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
      if (wr_en && !pop)      cnt_d = cnt_q + 1'b1;
      else if (pop && !wr_en) cnt_d = cnt_q - 1'b1;
      if (push && full && !pop) lap_ovf_d = 1'b1;
      if (clear) begin
         presc_d   = '0;
         sec_d     = '0;
         min_d     = '0;
         ovf_d     = 1'b0;
         rd_ptr_d  = '0;
         wr_ptr_d  = '0;
         cnt_d     = '0;
         lap_ovf_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_q   <= '0;
         sec_q     <= '0;
         min_q     <= '0;
         ovf_q     <= 1'b0;
         rd_ptr_q  <= '0;
         wr_ptr_q  <= '0;
         cnt_q     <= '0;
         lap_ovf_q <= 1'b0;
      end else begin
         presc_q   <= presc_d;
         sec_q     <= sec_d;
         min_q     <= min_d;
         ovf_q     <= ovf_d;
         rd_ptr_q  <= rd_ptr_d;
         wr_ptr_q  <= wr_ptr_d;
         cnt_q     <= cnt_d;
         lap_ovf_q <= lap_ovf_d;
      end
   end

   // Storage is never read while empty, so it needs no reset
   always_ff @(posedge clk) begin
      if (wr_en) begin
         sec_mem[wr_ptr_q] <= sec_q;
         min_mem[wr_ptr_q] <= min_q;
      end
   end

   always_comb begin
      seconds   = sec_q;
      minutes   = min_q;
      overflow  = ovf_q;
      lap_count = cnt_q;
      lap_ovf   = lap_ovf_q;
      lap_valid = (cnt_q != '0);
      lap_sec   = lap_valid ? sec_mem[rd_ptr_q] : '0;
      lap_min   = lap_valid ? min_mem[rd_ptr_q] : '0;
   end

endmodule
